// File: rtl/m_tone_divider_pkg.sv
// Shared constants and types for the multi-channel tone divider.
//   DEF_WIDTH    : default reload/counter width per channel
//   DEF_CHANNELS : default number of divider channels
//   ch_flags_t   : registered per-channel outputs (pulse, tone)
//   ch_state_t   : full channel state at the default width (R, C, pulse, tone)
//   sel_width()  : write-select width for a channel count (minimum 1)
package m_tone_divider_pkg;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_CHANNELS = 4;

    typedef struct packed {
        logic pulse;
        logic tone;
    } ch_flags_t;

    // Reference layout of one channel; m_div_channel holds the same fields at its WIDTH.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] r;
        logic [DEF_WIDTH-1:0] c;
        logic                 pulse;
        logic                 tone;
    } ch_state_t;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/m_div_channel.sv
// One divider channel: reload register, down-counter, terminal pulse and tone.
//   clk, rst_L : clock, asynchronous active-low reset
//   step_i     : count strobe for this channel (tick or linked terminal event)
//   run_i      : channel run enable
//   wr_i       : reload write for this channel (wins over a terminal event)
//   wr_data_i  : reload value
//   pulse_o    : one-cycle terminal-count strobe (registered)
//   tone_o     : square wave, toggles on every terminal event (registered)
//   count_o    : current counter value (registered)
//   term_o_c   : combinational terminal event this cycle, used for cascading
module m_div_channel
    import m_tone_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic             step_i,
    input  logic             run_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             pulse_o,
    output logic             tone_o,
    output logic [WIDTH-1:0] count_o,
    output logic             term_o_c
);

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] c_q, c_d;
    ch_flags_t        flg_q, flg_d;

    // A write suppresses the terminal event so the cascade never sees it.
    assign term_o_c = run_i & step_i & ~wr_i & (c_q == '0);

    // Next-state: write, terminal reload, decrement, or hold.
    always_comb begin
        r_d        = r_q;
        c_d        = c_q;
        flg_d.pulse = 1'b0;
        flg_d.tone  = flg_q.tone;
        if (wr_i) begin
            r_d = wr_data_i;
            c_d = wr_data_i;
        end else if (term_o_c) begin
            c_d         = r_q;
            flg_d.pulse = 1'b1;
            flg_d.tone  = ~flg_q.tone;
        end else if (run_i && step_i) begin
            c_d = c_q - WIDTH'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_q   <= '0;
            c_q   <= '0;
            flg_q <= '0;
        end else begin
            r_q   <= r_d;
            c_q   <= c_d;
            flg_q <= flg_d;
        end
    end

    assign pulse_o = flg_q.pulse;
    assign tone_o  = flg_q.tone;
    assign count_o = c_q;

endmodule

// File: rtl/m_tone_divider.sv
// Multi-channel programmable tone divider with shared prescaler tick.
// Optional feature macro: M_TONE_DIVIDER_LINK_EN adds input link[CHANNELS/2];
// link[k]=1 makes channel 2k+1 count on channel 2k's terminal event.
//   clk, rst_L : clock, asynchronous active-low reset
//   tick       : global prescaler strobe
//   wr_en      : reload write strobe
//   wr_sel     : channel written (out-of-range selects are ignored)
//   wr_data    : reload value
//   ch_en      : per-channel run enable
//   link       : per-pair cascade enable (macro builds only)
//   pulse      : per-channel terminal strobe (registered)
//   tone       : per-channel square wave (registered)
//   count      : counters, channel i at [i*WIDTH +: WIDTH] (registered)
module m_tone_divider
    import m_tone_divider_pkg::*;
#(
    parameter  int unsigned WIDTH    = DEF_WIDTH,
    parameter  int unsigned CHANNELS = DEF_CHANNELS,
    localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_L,
    input  logic                      tick,
    input  logic                      wr_en,
    input  logic [SEL_W-1:0]          wr_sel,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [CHANNELS-1:0]       ch_en,
`ifdef M_TONE_DIVIDER_LINK_EN
    input  logic [CHANNELS/2-1:0]     link,
`endif
    output logic [CHANNELS-1:0]       pulse,
    output logic [CHANNELS-1:0]       tone,
    output logic [CHANNELS*WIDTH-1:0] count
);

    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] step;
    logic [CHANNELS-1:0] term;

    // Write decode and channel array.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign wr_hit[i] = wr_en && (wr_sel == SEL_W'(i));

        m_div_channel #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .rst_L     (rst_L),
            .step_i    (step[i]),
            .run_i     (ch_en[i]),
            .wr_i      (wr_hit[i]),
            .wr_data_i (wr_data),
            .pulse_o   (pulse[i]),
            .tone_o    (tone[i]),
            .count_o   (count[i*WIDTH +: WIDTH]),
            .term_o_c  (term[i])
        );
    end

`ifdef M_TONE_DIVIDER_LINK_EN
    if ((CHANNELS % 2) != 0) begin : g_bad_channels
        $error("m_tone_divider: CHANNELS must be even when linking is enabled");
    end

    // Odd channel of each pair steps on its partner's terminal event when linked.
    for (genvar k = 0; k < CHANNELS / 2; k++) begin : g_link
        assign step[2*k]   = tick;
        assign step[2*k+1] = link[k] ? term[2*k] : tick;
    end
`else
    assign step = {CHANNELS{tick}};

    logic unused_term;
    assign unused_term = ^term;
`endif

endmodule

// File: tb/tb_m_tone_divider.sv
module tb_m_tone_divider;

    localparam int unsigned TB_W = 8;
`ifdef M_TONE_DIVIDER_LINK_EN
    localparam int unsigned TB_CH = 4;
`else
    localparam int unsigned TB_CH = 3;
`endif

    logic                    clk = 1'b0;
    logic                    rst_L;
    logic                    tick;
    logic                    wr_en;
    logic [1:0]              wr_sel;
    logic [TB_W-1:0]         wr_data;
    logic [TB_CH-1:0]        ch_en;
    logic [TB_CH-1:0]        pulse;
    logic [TB_CH-1:0]        tone;
    logic [TB_CH*TB_W-1:0]   count;

    always #5 clk = ~clk;

    m_tone_divider #(.WIDTH(TB_W), .CHANNELS(TB_CH)) dut (
        .clk     (clk),
        .rst_L   (rst_L),
        .tick    (tick),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .ch_en   (ch_en),
`ifdef M_TONE_DIVIDER_LINK_EN
        .link    ('0),
`endif
        .pulse   (pulse),
        .tone    (tone),
        .count   (count)
    );

`ifdef M_TONE_DIVIDER_LINK_EN
    logic       l_wr_en;
    logic       l_wr_sel;
    logic [3:0] l_wr_data;
    logic [1:0] l_en;
    logic [0:0] l_link;
    logic [1:0] l_pulse;
    logic [1:0] l_tone;
    logic [7:0] l_count;

    m_tone_divider #(.WIDTH(4), .CHANNELS(2)) dut_link (
        .clk     (clk),
        .rst_L   (rst_L),
        .tick    (tick),
        .wr_en   (l_wr_en),
        .wr_sel  (l_wr_sel),
        .wr_data (l_wr_data),
        .ch_en   (l_en),
        .link    (l_link),
        .pulse   (l_pulse),
        .tone    (l_tone),
        .count   (l_count)
    );
`endif

    typedef struct {
        logic [2:0] p;
        logic [2:0] t;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
        string      name;
    } exp_t;

    typedef struct {
        logic       tk;
        logic       wr;
        logic [1:0] sel;
        logic [7:0] data;
        logic [2:0] en;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    exp_t cur;
    vec_t vt[17];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mke(input logic [2:0] p, input logic [2:0] t, input logic [7:0] c0,
                                 input logic [7:0] c1, input logic [7:0] c2, input string nm);
        exp_t e;
        e.p = p; e.t = t; e.c0 = c0; e.c1 = c1; e.c2 = c2; e.name = nm;
        return e;
    endfunction

    function automatic vec_t mkv(input logic tk, input logic wr, input logic [1:0] sel,
                                 input logic [7:0] d, input logic [2:0] en, input exp_t e);
        vec_t v;
        v.tk = tk; v.wr = wr; v.sel = sel; v.data = d; v.en = en; v.e = e;
        return v;
    endfunction

    task automatic drive(input logic tk, input logic wr, input logic [1:0] sel,
                         input logic [7:0] d, input logic [2:0] en);
        @(negedge clk);
        tick    = tk;
        wr_en   = wr;
        wr_sel  = sel;
        wr_data = d;
        ch_en   = TB_CH'(en);
    endtask

    task automatic step_exp(input logic tk, input logic wr, input logic [1:0] sel,
                            input logic [7:0] d, input logic [2:0] en, input exp_t e);
        drive(tk, wr, sel, d, en);
        sb_q.push_back(e);
    endtask

    // Scoreboard: one expectation per driven cycle, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            cur = sb_q.pop_front();
            check({cur.name, ".pulse"},  32'(pulse[2:0]),     32'(cur.p));
            check({cur.name, ".tone"},   32'(tone[2:0]),      32'(cur.t));
            check({cur.name, ".count0"}, 32'(count[0 +: 8]),  32'(cur.c0));
            check({cur.name, ".count1"}, 32'(count[8 +: 8]),  32'(cur.c1));
            check({cur.name, ".count2"}, 32'(count[16 +: 8]), 32'(cur.c2));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before time 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tn;
        rst_L = 1'b0; tick = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0; ch_en = '0;
`ifdef M_TONE_DIVIDER_LINK_EN
        l_wr_en = 1'b0; l_wr_sel = 1'b0; l_wr_data = '0; l_en = '0; l_link = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        check("reset.pulse", 32'(pulse), 32'(0));
        check("reset.tone",  32'(tone),  32'(0));
        check("reset.count", 32'(count[23:0]), 32'(0));
        rst_L = 1'b1;

        // Ch0 R=3 period, tick gating, ch1 write/terminal collision, out-of-range write.
        vt[0]  = mkv(1, 1, 0, 3,  3'b001, mke(3'b000, 3'b000, 3, 0, 0, "v0_wr0"));
        vt[1]  = mkv(1, 0, 0, 0,  3'b001, mke(3'b000, 3'b000, 2, 0, 0, "v1"));
        vt[2]  = mkv(1, 0, 0, 0,  3'b001, mke(3'b000, 3'b000, 1, 0, 0, "v2"));
        vt[3]  = mkv(1, 0, 0, 0,  3'b001, mke(3'b000, 3'b000, 0, 0, 0, "v3"));
        vt[4]  = mkv(1, 0, 0, 0,  3'b001, mke(3'b001, 3'b001, 3, 0, 0, "v4_term"));
        vt[5]  = mkv(1, 0, 0, 0,  3'b001, mke(3'b000, 3'b001, 2, 0, 0, "v5"));
        vt[6]  = mkv(1, 0, 0, 0,  3'b001, mke(3'b000, 3'b001, 1, 0, 0, "v6"));
        vt[7]  = mkv(1, 0, 0, 0,  3'b001, mke(3'b000, 3'b001, 0, 0, 0, "v7"));
        vt[8]  = mkv(1, 0, 0, 0,  3'b001, mke(3'b001, 3'b000, 3, 0, 0, "v8_term"));
        vt[9]  = mkv(0, 0, 0, 0,  3'b001, mke(3'b000, 3'b000, 3, 0, 0, "v9_notick"));
        vt[10] = mkv(1, 0, 0, 0,  3'b010, mke(3'b010, 3'b010, 3, 0, 0, "v10_r0"));
        vt[11] = mkv(1, 1, 1, 5,  3'b010, mke(3'b000, 3'b010, 3, 5, 0, "v11_collide"));
        vt[12] = mkv(1, 0, 0, 0,  3'b010, mke(3'b000, 3'b010, 3, 4, 0, "v12"));
        vt[13] = mkv(1, 1, 3, 77, 3'b000, mke(3'b000, 3'b010, 3, 4, 0, "v13_badsel"));
        vt[14] = mkv(1, 1, 2, 4,  3'b000, mke(3'b000, 3'b010, 3, 4, 4, "v14_wr2"));
        vt[15] = mkv(1, 0, 0, 0,  3'b100, mke(3'b000, 3'b010, 3, 4, 3, "v15"));
        vt[16] = mkv(1, 0, 0, 0,  3'b100, mke(3'b000, 3'b010, 3, 4, 2, "v16"));
        for (int i = 0; i < 17; i++)
            step_exp(vt[i].tk, vt[i].wr, vt[i].sel, vt[i].data, vt[i].en, vt[i].e);

        // Ch2 frozen at 2 while disabled, then resumes 1, 0, reload.
        for (int i = 0; i < 10; i++)
            step_exp(1, 0, 0, 0, 3'b000, mke(3'b000, 3'b010, 3, 4, 2, "freeze"));
        step_exp(1, 0, 0, 0, 3'b100, mke(3'b000, 3'b010, 3, 4, 1, "resume1"));
        step_exp(1, 0, 0, 0, 3'b100, mke(3'b000, 3'b010, 3, 4, 0, "resume0"));
        step_exp(1, 0, 0, 0, 3'b100, mke(3'b100, 3'b110, 3, 4, 4, "resume_term"));

        // Ch1 R=0 with tick every third cycle: pulse after each tick, tone toggles.
        step_exp(0, 1, 1, 0, 3'b000, mke(3'b000, 3'b110, 3, 0, 4, "wr1_r0"));
        tn = 1'b1;
        for (int j = 0; j < 12; j++) begin
            if ((j % 3) == 0) tn = ~tn;
            step_exp(((j % 3) == 0), 0, 0, 0, 3'b010,
                     mke({2'b00, ((j % 3) == 0)} << 1, {1'b1, tn, 1'b0}, 3, 0, 4, "r0_tick3"));
        end

        // Ch0 R=255: first terminal pulse after exactly 256 ticks.
        step_exp(1, 1, 0, 255, 3'b000, mke(3'b000, {1'b1, tn, 1'b0}, 255, 0, 4, "wr0_max"));
        for (int k = 1; k <= 256; k++)
            step_exp(1, 0, 0, 0, 3'b001,
                     mke({2'b00, (k == 256)}, {1'b1, tn, (k == 256)},
                         (k == 256) ? 8'd255 : 8'(255 - k), 0, 4, "r_max"));

        // Async reset mid-count, between edges.
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 3'b001);
        @(posedge clk);
        #3;
        rst_L = 1'b0;
        #1;
        check("async_rst.pulse", 32'(pulse), 32'(0));
        check("async_rst.tone",  32'(tone),  32'(0));
        check("async_rst.count", 32'(count[23:0]), 32'(0));
        @(negedge clk);
        drive(0, 0, 0, 0, 3'b000);
        rst_L = 1'b1;

        // R=0 after reset: first tick pulses.
        step_exp(1, 0, 0, 0, 3'b001, mke(3'b001, 3'b001, 0, 0, 0, "post_rst_tick"));
        step_exp(0, 0, 0, 0, 3'b001, mke(3'b000, 3'b001, 0, 0, 0, "post_rst_idle"));
        drive(0, 0, 0, 0, 3'b000);
        @(posedge clk);
        #2;
        check("sb_drained", 32'(sb_q.size()), 32'(0));

`ifdef M_TONE_DIVIDER_LINK_EN
        // Cascaded pair: R0=1, R1=2 -> pulse[1] every 6 ticks; unlinked every 3.
        @(negedge clk); l_wr_en = 1'b1; l_wr_sel = 1'b0; l_wr_data = 4'd1;
        @(negedge clk); l_wr_sel = 1'b1; l_wr_data = 4'd2;
        @(negedge clk); l_wr_en = 1'b0; l_en = 2'b11; l_link = 1'b1; tick = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            check("link_on.pulse1", 32'(l_pulse[1]), 32'((k % 6) == 0));
        end
        @(negedge clk); l_link = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            check("link_off.pulse1", 32'(l_pulse[1]), 32'((k % 3) == 0));
        end
        @(negedge clk); tick = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/m_tone_divider.md
M_TONE_DIVIDER -- requirements
Module: m_tone_divider

Interface
- REQ-001: Parameter WIDTH, default 8, is the reload/counter width in bits per channel (legal ≥2).
- REQ-002: Parameter CHANNELS, default 4, is the number of independent divider channels (legal ≥1).
- REQ-003: clk  input  1  is the single clock; all state updates on posedge clk.
- REQ-004: rst_L  input  1  is the reset: asynchronous, active-low.
- REQ-005: tick  input  1  is the global prescaler strobe; counting occurs only on cycles with tick=1.
- REQ-006: wr_en  input  1  is the write strobe for a channel reload value.
- REQ-007: wr_sel  input  $clog2(CHANNELS) (min 1)  selects the channel written.
- REQ-008: wr_data  input  WIDTH  is the reload value written.
- REQ-009: ch_en  input  CHANNELS  is the per-channel run enable.
- REQ-010: pulse  output  CHANNELS  is the per-channel one-cycle terminal-count strobe, registered.
- REQ-011: tone  output  CHANNELS  is the per-channel square wave, registered.
- REQ-012: count  output  CHANNELS*WIDTH  is the current counter values, channel i at bits [i*WIDTH +: WIDTH].

Function
- REQ-013: Each channel SHALL hold a reload register R and a down-counter C, both WIDTH bits.
- REQ-014: wr_en=1 with wr_sel=i SHALL set R[i] and C[i] to wr_data at that edge, with pulse[i]=0 next cycle; tone[i] unchanged.
- REQ-015: wr_sel ≥ CHANNELS SHALL make the write a no-op.
- REQ-016: Channel with ch_en=1, tick=1, no write, and C≠0 SHALL decrement C by 1; pulse=0.
- REQ-017: Channel with ch_en=1, tick=1, no write, and C=0 SHALL reload C←R, set pulse=1 for exactly the next cycle, and invert tone.
- REQ-018: Terminal period SHALL be R+1 ticks; R=0 SHALL pulse on every tick; R=2^WIDTH-1 SHALL give 2^WIDTH ticks.
- REQ-019: A write and a terminal event on the same channel in the same cycle SHALL resolve with the write winning: no pulse, no tone toggle.
- REQ-020: ch_en[i]=0 SHALL freeze C[i] and tone[i], force pulse[i]=0, and still accept writes.
- REQ-021: tick=0 SHALL hold all counters and force all pulse bits to 0.
- REQ-022: Channels SHALL be fully independent except for the shared tick and the write port.

Reset
- REQ-023: rst_L=0 SHALL immediately clear all R, C, pulse and tone to 0, regardless of clk, including mid-count.
- REQ-024: After reset release, with R=0 and ch_en=1, the first tick SHALL produce a pulse.

Configuration
- REQ-025: Macro M_TONE_DIVIDER_LINK_EN, when defined, SHALL add input link, width CHANNELS/2, and SHALL require CHANNELS even.
- REQ-026: With the macro defined and link[k]=1, channel 2k+1 SHALL count on channel 2k's terminal event (same cycle it occurs) instead of on tick, forming a 2*WIDTH-bit cascaded divider; channel 2k pulse/tone SHALL be unaffected.
- REQ-027: Without the macro, the link port SHALL be absent and every channel SHALL count on tick.

Structure
- REQ-028: Package m_tone_divider_pkg SHALL hold default WIDTH/CHANNELS constants and the channel-state typedef (R, C, pulse, tone).
- REQ-029: One channel SHALL be sub-module m_div_channel, instantiated CHANNELS times by generate; the top SHALL hold write decode and link muxing.

Verification
- REQ-030: Reset; write ch0=3; ch_en=1; tick every cycle -> pulse[0] every 4 cycles; tone[0] period 8 cycles; count[0] sequence 3,2,1,0,3.
- REQ-031: R=0, tick every 3rd cycle -> pulse on each tick cycle+1, one cycle wide; tone toggles each tick.
- REQ-032: ch1 C=0 on tick while writing ch1=5 same cycle -> no pulse, count[1]=5, tone[1] unchanged.
- REQ-033: ch_en[2] dropped at count 2 for 10 cycles -> count held at 2, no pulse; resumes 1,0 on re-enable.
- REQ-034: rst_L asserted between clock edges mid-count -> all outputs 0 before next edge; wr_sel=CHANNELS write -> no change.
- REQ-035: With M_TONE_DIVIDER_LINK_EN, WIDTH=4, link[0]=1, R0=1, R1=2 -> pulse[1] every 6 ticks; link[0]=0 -> every 3 ticks.
